// File: rtl/prbs31_chk.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-seeds from the received stream,
// qualifies lock, then free-runs a local reference and counts bit errors.
module prbs31_chk #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WIN        = 128,
  parameter int unsigned UNLOCK_ERR = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prbs_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat
);

  localparam int unsigned WIN_W = $clog2(WIN);
  localparam int unsigned ERR_W = $clog2(UNLOCK_ERR + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
  localparam logic [ERR_W:0]   UNLOCK_V = (ERR_W + 1)'(UNLOCK_ERR);
  localparam logic [15:0]      GOOD_LAST = 16'(LOCK_CNT - 1);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_e;

  state_e           state_q;
  logic [30:0]      h_q;
  logic [4:0]       seed_q;
  logic [15:0]      good_q;
  logic [WIN_W-1:0] win_q;
  logic [ERR_W-1:0] werr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, locked_q, pulse_q;

  logic             pred, mis, cnt_inc;
  logic [ERR_W:0]   werr_sum;

  always_comb begin
    pred     = h_q[30] ^ h_q[27];
    mis      = prbs_in ^ pred;
    werr_sum = {1'b0, werr_q} + {{ERR_W{1'b0}}, mis};
    cnt_inc  = en && (state_q == LOCKED) && mis && !(&cnt_q);
    cnt_d    = cnt_q;
    if (clr_cnt)      cnt_d = '0;
    else if (cnt_inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED;
      h_q      <= '0;
      seed_q   <= '0;
      good_q   <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      cnt_q   <= cnt_d;
      sat_q   <= &cnt_d;
      if (en) begin
        // Once locked the reference regenerates itself, so line errors never enter h.
        h_q <= {h_q[29:0], (state_q == LOCKED) ? pred : prbs_in};
        unique case (state_q)
          SEED: begin
            if (seed_q == 5'd30) begin
              state_q <= HUNT;
              seed_q  <= '0;
              good_q  <= '0;
            end else begin
              seed_q <= seed_q + 5'd1;
            end
          end
          HUNT: begin
            if (!mis && (h_q != '0)) begin
              if (good_q == GOOD_LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                good_q   <= '0;
                win_q    <= '0;
                werr_q   <= '0;
              end else begin
                good_q <= good_q + 16'd1;
              end
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            pulse_q <= mis;
            // Threshold takes precedence over the end-of-window clear.
            if (werr_sum >= UNLOCK_V) begin
              state_q  <= SEED;
              locked_q <= 1'b0;
              seed_q   <= '0;
              good_q   <= '0;
              win_q    <= '0;
              werr_q   <= '0;
            end else if (win_q == WIN_LAST) begin
              win_q  <= '0;
              werr_q <= '0;
            end else begin
              win_q  <= win_q + WIN_W'(1);
              werr_q <= werr_sum[ERR_W-1:0];
            end
          end
          default: state_q <= SEED;
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_cnt   = cnt_q;
  assign err_sat   = sat_q;

endmodule

// File: tb/tb_prbs31_chk.sv
// Scoreboard bench for prbs31_chk: a 16-bit and a 3-bit counter instance share
// one stimulus stream from a PRBS31 generator with deliberate bit inversions.
module tb_prbs31_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, prbs_in, clr_cnt;
  logic lk16, pl16, s16, lk3, pl3, s3;
  logic [15:0] c16;
  logic [2:0]  c3;

  prbs31_chk #(.CNT_W(16), .LOCK_CNT(64), .WIN(128), .UNLOCK_ERR(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .prbs_in(prbs_in), .clr_cnt(clr_cnt),
    .locked(lk16), .err_pulse(pl16), .err_cnt(c16), .err_sat(s16));

  prbs31_chk #(.CNT_W(3), .LOCK_CNT(64), .WIN(128), .UNLOCK_ERR(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .prbs_in(prbs_in), .clr_cnt(clr_cnt),
    .locked(lk3), .err_pulse(pl3), .err_cnt(c3), .err_sat(s3));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [15:0] c16;
    logic        s16;
    logic [2:0]  c3;
    logic        s3;
  } exp_t;

  exp_t sb[$];

  // Reference generator and expected-behaviour model
  logic [30:0] g;
  logic        zero_mode;
  int m_state, m_seed, m_good, m_wpos, m_werr, m_c16, m_c3;
  logic m_pl;

  task automatic model_reset();
    m_state = 0; m_seed = 0; m_good = 0; m_wpos = 0; m_werr = 0;
    m_c16 = 0; m_c3 = 0; m_pl = 1'b0;
  endtask

  task automatic compare_pending();
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("d16", {lk16, pl16, s16, c16}, {x.lk, x.pl, x.s16, x.c16});
      check("d3",  {lk3, pl3, s3, c3},     {x.lk, x.pl, x.s3, x.c3});
    end
  endtask

  task automatic step(input logic e, input logic inj, input logic clr);
    exp_t x;
    logic tb;
    @(negedge clk);
    compare_pending();
    tb      = zero_mode ? 1'b0 : (g[30] ^ g[27]);
    en      = e;
    clr_cnt = clr;
    prbs_in = tb ^ inj;
    m_pl    = 1'b0;
    if (e) begin
      if (!zero_mode) g = {g[29:0], tb};
      case (m_state)
        0: begin
          m_seed++;
          if (m_seed == 31) begin m_state = 1; m_good = 0; end
        end
        1: begin
          if (!inj && !zero_mode) begin
            m_good++;
            if (m_good == 64) begin m_state = 2; m_wpos = 0; m_werr = 0; end
          end else m_good = 0;
        end
        default: begin
          m_pl = inj;
          if (inj) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c3 < 7) m_c3++;
          end
          if (m_werr + int'(inj) >= 8) begin
            m_state = 0; m_seed = 0; m_good = 0; m_wpos = 0; m_werr = 0;
          end else if (m_wpos == 127) begin
            m_wpos = 0; m_werr = 0;
          end else begin
            m_wpos++; m_werr += int'(inj);
          end
        end
      endcase
    end
    if (clr) begin m_c16 = 0; m_c3 = 0; end
    x.lk  = (m_state == 2);
    x.pl  = m_pl;
    x.c16 = m_c16[15:0];
    x.s16 = (m_c16 == 65535);
    x.c3  = m_c3[2:0];
    x.s3  = (m_c3 == 7);
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_pending();
    rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0;
    #1;
    check("rst16", {lk16, pl16, s16, c16}, 32'h0);
    check("rst3",  {lk3, pl3, s3, c3},     32'h0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_wpos(input int p);
    int n = 0;
    while ((m_wpos != p || m_state != 2) && n < 300) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    if (m_wpos != p) check("wpos_timeout", 32'(m_wpos), 32'(p));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; prbs_in = 1'b0; clr_cnt = 1'b0;
    g = 31'h55555555; zero_mode = 1'b0;
    model_reset();
    do_reset();

    // Clean lock, then a long error-free run
    repeat (95 + 10000) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_locked", 32'(lk16), 32'd1);
    check("t1_cnt", 32'(c16), 32'd0);

    // Single inverted bit
    step(1'b1, 1'b1, 1'b0);
    repeat (200) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t2_locked", 32'(lk16), 32'd1);
    check("t2_cnt", 32'(c16), 32'd1);

    // Eight errors spaced 10 apart inside one window force unlock
    wait_wpos(0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i < 7) repeat (9) step(1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("t3_unlock", 32'(lk16), 32'd0);
    check("t3_cnt", 32'(c16), 32'd9);
    repeat (95) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t3_relock", 32'(lk16), 32'd1);

    // Random en duty cycle
    do_reset();
    for (int i = 0; i < 400 && m_state != 2; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_locked", 32'(lk16), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    repeat (50) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_cnt", 32'(c16), 32'd1);
    check("t4_locked2", 32'(lk16), 32'd1);

    // One error per window for nine windows saturates the 3-bit counter
    for (int w = 0; w < 9; w++) begin
      wait_wpos(5);
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("t5_c3", 32'(c3), 32'd7);
    check("t5_s3", 32'(s3), 32'd1);
    check("t5_c16", 32'(c16), 32'd10);
    check("t5_locked", 32'(lk3), 32'd1);

    // Clear wins over a same-cycle error
    wait_wpos(5);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("t6_c3", 32'(c3), 32'd0);
    check("t6_s3", 32'(s3), 32'd0);
    check("t6_c16", 32'(c16), 32'd0);
    check("t6_pulse", 32'(pl16), 32'd1);

    // Asynchronous reset while locked, then an all-zero stream
    do_reset();
    zero_mode = 1'b1;
    repeat (1000) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t7_locked", 32'(lk16), 32'd0);
    check("t7_cnt", 32'(c16), 32'd0);
    zero_mode = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs31_chk.md
# prbs31_chk

Serial PRBS31 checker (polynomial x^31 + x^28 + 1) for the SerDes test path. It receives the one-bit-per-clock stream produced by the PRBS31 generator after the link, self-seeds from the incoming bits and qualifies lock. Once locked it free-runs a local reference, flags every mismatching bit and accumulates a saturating error count for BER measurement. It drops lock on an error burst.

## Interface
- CNT_W, 16, width of the error counter
- LOCK_CNT, 64, consecutive good bits in HUNT required to declare lock (1..2^16-1)
- WIN, 128, LOCKED-state supervision window, in valid bits (power of 2, ≥ UNLOCK_ERR)
- UNLOCK_ERR, 8, errors within one window that force loss of lock
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  prbs_in valid this cycle; all state frozen when low
- prbs_in  in  1  received serial bit
- clr_cnt  in  1  synchronous clear of err_cnt/err_sat
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle flag: the previous valid bit mismatched while LOCKED
- err_cnt  out  CNT_W  saturating count of LOCKED-state bit errors
- err_sat  out  1  err_cnt == 2^CNT_W-1

## Operation
- Recurrence: b[t] = b[t-31] ^ b[t-28].
- History register h[30:0]: h[k] = bit k+1 valid cycles ago.
- Prediction: pred = h[30] ^ h[27].
- Mismatch: mis = prbs_in ^ pred.
- On each en cycle, h shifts left. The new h[0] is prbs_in in SEED/HUNT and pred in LOCKED, so the reference free-runs when locked and a single line error yields exactly one flag.
- States (one-hot or binary, implementer's choice):
  - SEED: fill h with 31 valid bits (seed counter 0..30). After the 31st, go to HUNT. No error reporting.
  - HUNT: a bit is good if mis==0 and h!=0. Good increments good_cnt. Otherwise good_cnt=0 and the state stays HUNT. When good_cnt reaches LOCK_CNT (on that bit), go to LOCKED. All-zero input never locks.
  - LOCKED:
    - win_cnt counts valid bits 0..WIN-1 with wrap.
    - win_err counts mis within the window.
    - If win_err+mis reaches UNLOCK_ERR, go to SEED. Seed counter, good_cnt, win_cnt and win_err are cleared.
    - On the last bit of a window (threshold evaluated first), win_err is cleared to 0.
- err_cnt increments on en & mis in LOCKED only, including the bit that causes unlock. It saturates at 2^CNT_W-1 and never wraps.
- clr_cnt has priority over a same-cycle increment: result is 0.
- en low: no shift, no counter change, no state change. err_pulse is 0.

## Timing
- Reset: state SEED, h=0, all internal counters 0. Outputs: locked=0, err_pulse=0, err_cnt=0, err_sat=0.
- All outputs are registered. err_pulse, err_cnt and locked update on the clock edge that samples the bit: visible in the cycle after en&prbs_in were presented. Latency is 1 cycle.
- Lock time from reset with a clean stream: locked rises after 31 + LOCK_CNT valid bits, i.e. 95 by default.
- Unlock: locked falls in the cycle after the bit that brings win_err to UNLOCK_ERR. That bit still produces err_pulse and an increment.
- err_sat is registered alongside err_cnt. It is cleared by clr_cnt.
- Asynchronous reset mid-operation returns immediately to the reset values. Relock requires the full 31 + LOCK_CNT bits.
- Throughput: one bit per clk with en held high. There is no back-pressure.

## Test plan
- Generator reference (seed 31'h55555555, x^31+x^28) drives prbs_in with en=1 from reset release -> locked rises after exactly 95 bits. err_pulse stays 0 and err_cnt stays 0 for 10000 further bits.
- Clean lock, then invert one bit -> exactly one err_pulse one cycle later and err_cnt=1. No further flags, locked stays 1.
- Lock, then invert 8 bits spaced 10 apart within one 128-bit window -> err_cnt=8 and locked falls after the 8th. With a clean stream, locked returns after 95 more bits.
- en toggled with pseudo-random 50% duty, stream advanced only on en -> lock after 95 valid bits. Error injection as in the single-bit test gives identical counts.
- prbs_in held 0 for 1000 cycles -> never locks. err_cnt stays 0.
- CNT_W=3, UNLOCK_ERR=8:
  - Inject one error per 128-bit window for 9 windows -> err_cnt stops at 7 with err_sat=1.
  - Assert clr_cnt on a cycle with a flagged error -> err_cnt=0, err_sat=0.
  - Assert rst_n low mid-lock -> all outputs 0 immediately.
